// File: rtl/traffic_phase_scheduler.sv
// Five-phase round-robin intersection scheduler: four vehicle phases plus a latched
// pedestrian walk phase, with min/max green, yellow, all-red clearance and walk timing.
module traffic_phase_scheduler #(
  parameter int unsigned GREEN_MIN = 5,
  parameter int unsigned GREEN_MAX = 10,
  parameter int unsigned YELLOW_T  = 2,
  parameter int unsigned ALLRED_T  = 1,
  parameter int unsigned WALK_T    = 8,
  parameter int unsigned CNT_W     = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ew_str_sensor,
  input  logic       ew_left_sensor,
  input  logic       ns_str_sensor,
  input  logic       ns_left_sensor,
  input  logic       ped_button,
  output logic [1:0] ew_str_light,
  output logic [1:0] ew_left_light,
  output logic [1:0] ns_str_light,
  output logic [1:0] ns_left_light,
  output logic       walk,
  output logic [2:0] active_phase
);

  localparam logic [1:0] LT_RED = 2'b00;
  localparam logic [1:0] LT_YEL = 2'b01;
  localparam logic [1:0] LT_GRN = 2'b10;
  localparam logic [2:0] PH_PED  = 3'd4;
  localparam logic [2:0] PH_NONE = 3'd7;

  localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] CLR_LAST  = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(WALK_T - 1);

  typedef enum logic [2:0] {S_IDLE, S_GREEN, S_YELLOW, S_CLEAR, S_WALK} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d, timer_inc;
  logic [2:0]       last_q, last_d;
  logic             ped_pend_q, ped_pend_d;
  logic [3:0][1:0]  light_q, light_d;
  logic             walk_q, walk_d;
  logic [2:0]       active_q, active_d;

  logic [4:0] req;
  logic [3:0] pick;
  logic       arb, ped_grant, own_req, other_req;

  // First requester after `last`, wrapping over the five phases; bit 3 flags a hit.
  function automatic logic [3:0] rr_pick(input logic [4:0] r, input logic [2:0] last);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0000;
    idx = last;
    for (int k = 0; k < 5; k++) begin
      idx = (idx == 3'd4) ? 3'd0 : idx + 3'd1;
      if (!res[3] && r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign req       = {ped_pend_q, ns_left_sensor, ns_str_sensor, ew_left_sensor, ew_str_sensor};
  assign pick      = rr_pick(req, last_q);
  assign own_req   = req[last_q];
  assign other_req = |(req & ~(5'b00001 << last_q));
  assign timer_inc = (timer_q == '1) ? timer_q : timer_q + CNT_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      last_q     <= PH_PED;
      ped_pend_q <= 1'b0;
      light_q    <= '0;
      walk_q     <= 1'b0;
      active_q   <= PH_NONE;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      last_q     <= last_d;
      ped_pend_q <= ped_pend_d;
      light_q    <= light_d;
      walk_q     <= walk_d;
      active_q   <= active_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    last_d    = last_q;
    arb       = 1'b0;
    ped_grant = 1'b0;
    light_d   = '0;
    walk_d    = 1'b0;
    active_d  = PH_NONE;

    unique case (state_q)
      S_IDLE: arb = 1'b1;
      S_GREEN: begin
        if ((timer_q >= GMIN_LAST && !own_req) || (timer_q >= GMAX_LAST && other_req)) begin
          state_d = S_YELLOW;
          timer_d = '0;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_YELLOW: begin
        if (timer_q == YEL_LAST) begin
          state_d = S_CLEAR;
          timer_d = '0;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_WALK: begin
        if (timer_q == WALK_LAST) begin
          state_d = S_CLEAR;
          timer_d = '0;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_CLEAR: begin
        if (timer_q == CLR_LAST) arb = 1'b1;
        else                     timer_d = timer_inc;
      end
      default: state_d = S_IDLE;
    endcase

    if (arb) begin
      timer_d = '0;
      if (pick[3]) begin
        last_d    = pick[2:0];
        ped_grant = (pick[2:0] == PH_PED);
        state_d   = ped_grant ? S_WALK : S_GREEN;
      end else begin
        state_d = S_IDLE;
      end
    end

    ped_pend_d = (ped_pend_q & ~ped_grant) | ped_button;

    // Registered light heads follow the state being entered.
    unique case (state_d)
      S_GREEN: begin
        light_d[last_d[1:0]] = LT_GRN;
        active_d             = last_d;
      end
      S_YELLOW: begin
        light_d[last_d[1:0]] = LT_YEL;
        active_d             = last_d;
      end
      S_WALK: begin
        walk_d   = 1'b1;
        active_d = PH_PED;
      end
      default: light_d = {4{LT_RED}};
    endcase
  end

  assign ew_str_light  = light_q[0];
  assign ew_left_light = light_q[1];
  assign ns_str_light  = light_q[2];
  assign ns_left_light = light_q[3];
  assign walk          = walk_q;
  assign active_phase  = active_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench for traffic_phase_scheduler: a script-based reference model queues the
// expected light/walk/phase tuple per cycle; a monitor pops and compares, plus invariants.
module tb_traffic_phase_scheduler;

  localparam int GREEN_MIN = 5;
  localparam int GREEN_MAX = 10;
  localparam int YELLOW_T  = 2;
  localparam int ALLRED_T  = 1;
  localparam int WALK_T    = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ew_str_sensor = 1'b0, ew_left_sensor = 1'b0;
  logic       ns_str_sensor = 1'b0, ns_left_sensor = 1'b0;
  logic       ped_button = 1'b0;
  logic [1:0] ew_str_light, ew_left_light, ns_str_light, ns_left_light;
  logic       walk;
  logic [2:0] active_phase;

  always #5 clk = ~clk;

  traffic_phase_scheduler dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ew_str_sensor  (ew_str_sensor),
    .ew_left_sensor (ew_left_sensor),
    .ns_str_sensor  (ns_str_sensor),
    .ns_left_sensor (ns_left_sensor),
    .ped_button     (ped_button),
    .ew_str_light   (ew_str_light),
    .ew_left_light  (ew_left_light),
    .ns_str_light   (ns_str_light),
    .ns_left_light  (ns_left_light),
    .walk           (walk),
    .active_phase   (active_phase)
  );

  // {ew_str, ew_left, ns_str, ns_left lights, walk, active_phase}
  typedef logic [11:0] out_t;
  localparam out_t ALL_RED = 12'b00_00_00_00_0_111;

  out_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: a grant either holds green (age-tracked) or plays a fixed script.
  int   m_last;
  bit   m_ped;
  bit   m_in_green;
  int   m_age;
  int   m_cur;
  out_t m_script[$];

  function automatic out_t mk_out(input int phase, input logic [1:0] lt, input logic w,
                                  input logic [2:0] act);
    logic [7:0] l;
    l = 8'h00;
    if (phase >= 0 && phase < 4) l[7-2*phase -: 2] = lt;
    return {l, w, act};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h, at t=%0t", name, act, req, $time);
  endtask

  task automatic model_reset();
    m_last     = 4;
    m_ped      = 1'b0;
    m_in_green = 1'b0;
    m_age      = 0;
    m_cur      = 0;
    m_script.delete();
    exp_q.push_back(ALL_RED);
  endtask

  task automatic model_step(input logic [3:0] sens, input logic btn);
    logic [4:0] req;
    bit         other, granted_ped;
    int         w, p;
    out_t       o;
    req         = {m_ped, sens};
    granted_ped = 1'b0;
    other       = 1'b0;
    w           = -1;
    if (m_in_green) begin
      for (int i = 0; i < 5; i++) if (i != m_cur && req[i]) other = 1'b1;
      if ((m_age >= GREEN_MIN && !req[m_cur]) || (m_age >= GREEN_MAX && other)) begin
        m_in_green = 1'b0;
        for (int i = 0; i < YELLOW_T; i++) m_script.push_back(mk_out(m_cur, 2'b01, 1'b0, 3'(m_cur)));
        for (int i = 0; i < ALLRED_T; i++) m_script.push_back(ALL_RED);
        o = m_script.pop_front();
      end else begin
        m_age++;
        o = mk_out(m_cur, 2'b10, 1'b0, 3'(m_cur));
      end
    end else if (m_script.size() > 0) begin
      o = m_script.pop_front();
    end else begin
      for (int k = 1; k <= 5; k++) begin
        p = (m_last + k) % 5;
        if (w < 0 && req[p]) w = p;
      end
      if (w < 0) begin
        o = ALL_RED;
      end else begin
        m_last = w;
        m_cur  = w;
        if (w == 4) begin
          granted_ped = 1'b1;
          o = mk_out(-1, 2'b00, 1'b1, 3'd4);
          for (int i = 0; i < WALK_T - 1; i++) m_script.push_back(mk_out(-1, 2'b00, 1'b1, 3'd4));
          for (int i = 0; i < ALLRED_T; i++)   m_script.push_back(ALL_RED);
        end else begin
          m_in_green = 1'b1;
          m_age      = 1;
          o = mk_out(w, 2'b10, 1'b0, 3'(w));
        end
      end
    end
    m_ped = (m_ped && !granted_ped) || btn;
    exp_q.push_back(o);
  endtask

  // One clock of stimulus: inputs change on the falling edge, the model predicts the next edge.
  task automatic step(input logic [3:0] sens, input logic btn, input logic rst_low);
    @(negedge clk);
    {ns_left_sensor, ns_str_sensor, ew_left_sensor, ew_str_sensor} = sens;
    ped_button = btn;
    reset_n    = !rst_low;
    if (rst_low) model_reset();
    else         model_step(sens, btn);
    @(posedge clk);
  endtask

  task automatic run(input logic [3:0] sens, input int n);
    for (int i = 0; i < n; i++) step(sens, 1'b0, 1'b0);
  endtask

  // Monitor: compares every registered output update and checks the safety invariants.
  initial begin : monitor
    out_t       act, prev, e;
    logic [1:0] lt, pl;
    int         nonred;
    bit         bad;
    prev = ALL_RED;
    forever begin
      @(posedge clk);
      #1;
      act = {ew_str_light, ew_left_light, ns_str_light, ns_left_light, walk, active_phase};
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("outputs", 32'(act), 32'(e));
      end
      bad    = 1'b0;
      nonred = 0;
      for (int p = 0; p < 4; p++) begin
        lt = act[11-2*p -: 2];
        pl = prev[11-2*p -: 2];
        if (lt != 2'b00) nonred++;
        if (lt == 2'b11) bad = 1'b1;
        if (reset_n && pl == 2'b10 && lt == 2'b00) bad = 1'b1;
      end
      if (nonred > 1) bad = 1'b1;
      if (act[3] && act[11:4] != 8'h00) bad = 1'b1;
      n_checks++;
      if (!bad) n_pass++;
      else $display("FAIL invariant: got lights=%b walk=%b prev=%b, required one-hot legal sequence",
                    act[11:4], act[3], prev[11:4]);
      prev = act;
    end
  end

  initial begin : stimulus
    bit         seen;
    logic [3:0] rs;
    logic       rb, rr;
    seen = 1'b0;
    rs   = 4'b0000;

    // Reset, then a 3-cycle ew_str pulse: 5 green, 2 yellow, 1 red, idle.
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b0, 1'b1);
    run(4'b0001, 3);
    run(4'b0000, 12);

    // Everything requesting: max-green rotation 0..3 then walk; a second press later.
    step(4'b1111, 1'b1, 1'b0);
    run(4'b1111, 70);
    step(4'b1111, 1'b1, 1'b0);
    run(4'b1111, 70);
    run(4'b0000, 20);

    // Lone ns_str hold, then the same hold interrupted by ew_left.
    run(4'b0100, 40);
    run(4'b0000, 10);
    run(4'b0100, 20);
    run(4'b0110, 8);
    run(4'b0000, 20);

    // Ped pulse during ew_str green, then another pulse during the walk.
    run(4'b0001, 2);
    step(4'b0001, 1'b1, 1'b0);
    run(4'b0001, 4);
    run(4'b0000, 5);
    step(4'b0000, 1'b1, 1'b0);
    run(4'b0001, 25);
    run(4'b0000, 25);

    // Asynchronous reset in the middle of a yellow.
    step(4'b0001, 1'b0, 1'b0);
    for (int i = 0; i < 20 && !seen; i++) begin
      step(4'b0000, 1'b0, 1'b0);
      #1;
      if (ew_str_light == 2'b01) seen = 1'b1;
    end
    check("yellow_reached", 32'(seen), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_reset", 32'({ew_str_light, ew_left_light, ns_str_light, ns_left_light, walk,
                              active_phase}), 32'(ALL_RED));
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    run(4'b0110, 20);
    run(4'b0000, 10);

    // Randomized run with slowly toggling sensors, sparse ped presses and rare resets.
    for (int i = 0; i < 10000; i++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(11) == 0) rs[b] = ~rs[b];
      rb = ($urandom_range(39) == 0);
      rr = ($urandom_range(1999) == 0);
      step(rs, rb, rr);
    end
    run(4'b0000, 40);

    #2;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
- Five-phase intersection scheduler for a four-approach intersection with a pedestrian crossing.
- Phases:
  - ew_str (0), ew_left (1), ns_str (2), ns_left (3): vehicle phases, driven by level sensors.
  - ped (4): walk phase, driven by a latched push-button.
- Grants phases round-robin with programmable minimum green, maximum green, yellow, all-red clearance and walk times.
- Drives the light heads directly; never more than one phase non-red.

Parameters:
- GREEN_MIN, 5: minimum green cycles per vehicle grant (≥1).
- GREEN_MAX, 10: green cap when any other request is pending (≥GREEN_MIN).
- YELLOW_T, 2: yellow cycles (≥1).
- ALLRED_T, 1: all-red clearance cycles after yellow or walk (≥1).
- WALK_T, 8: walk cycles (≥1).
- CNT_W, 8: phase timer width; must hold max(GREEN_MAX, WALK_T).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ew_str_sensor  in  1  EW through traffic present (level).
- ew_left_sensor  in  1  EW left-turn traffic present (level).
- ns_str_sensor  in  1  NS through traffic present (level).
- ns_left_sensor  in  1  NS left-turn traffic present (level).
- ped_button  in  1  pedestrian request (pulse or level); latched internally.
- ew_str_light  out  2  red=00, yellow=01, green=10; 11 never driven.
- ew_left_light  out  2  same encoding.
- ns_str_light  out  2  same encoding.
- ns_left_light  out  2  same encoding.
- walk  out  1  pedestrian walk indication.
- active_phase  out  3  index of the granted phase (0-4); 7 when all red.

Behaviour:
- All outputs are registered.
- Reset (reset_n low, asynchronous, also mid-operation):
  - all lights 00, walk=0, active_phase=7;
  - state=IDLE, timer=0, ped_pending=0;
  - last_served=4, so the search starts at phase 0.
- Request vector: req[0..3] = vehicle sensors; req[4] = ped_pending.
- ped_pending update each edge: next = (ped_pending & ~ped_grant) | ped_button. A press on the grant edge stays pending.
- States: IDLE, GREEN, YELLOW, CLEAR, WALK.
- Arbitration happens in IDLE, or on the last CLEAR cycle.
  - Winner: first set req index scanning (last_served+1) mod 5 upward, wrapping.
  - On the arbitration edge, the winner's light becomes green (or walk=1 for ped).
  - last_served ← winner, timer ← 0, active_phase ← winner.
  - No request: go to / stay in IDLE, all red.
- GREEN, timer counts completed green cycles minus 1. Exit to YELLOW (timer←0) when either:
  - timer ≥ GREEN_MIN-1 and own sensor low; or
  - timer ≥ GREEN_MAX-1 and any other req set.
  - Otherwise hold. A lone held sensor holds green indefinitely. The timer saturates at all-ones.
- Green therefore lasts at least GREEN_MIN cycles. A sensor dropping early does not shorten it.
- YELLOW: light=01 for exactly YELLOW_T cycles, then CLEAR.
- WALK: walk=1 for exactly WALK_T cycles, vehicle lights red, then CLEAR.
- CLEAR: all red, walk=0, active_phase=7, for exactly ALLRED_T cycles; the last cycle arbitrates.
- Sensors are sampled only at arbitration and exit evaluation; no sensor latching.
- Simultaneous requests are resolved purely by round-robin order. After reset the order is ew_str, ew_left, ns_str, ns_left, ped.
- Invariants checked by assertion:
  - at most one light non-red;
  - walk=1 implies all lights red;
  - no light ever 11;
  - green→red always passes through yellow.

Test Plan:
- Directed scenarios use default parameters; cycle counts assume them.
- Reset then ew_str_sensor pulsed 3 cycles → ew_str green 5 cycles, yellow 2, all-red 1; then IDLE, all 00, active_phase=7.
- All four sensors and ped_button asserted together from IDLE, held → grants in order 0,1,2,3,4,0…:
  - each vehicle green exactly 10 cycles (GREEN_MAX), then yellow 2, red 1;
  - walk 8 cycles;
  - ped re-granted only if pressed again.
- ns_str_sensor held alone 40 cycles → ns_str green continuously for 40+ cycles until sensor drop (≥5 total), then yellow/clear.
  - Raising ew_left_sensor mid-hold at green cycle 20 → green ends after that cycle's evaluation, then ew_left granted.
- ped_button 1-cycle pulse during an ew_str green → ped_pending=1; after ew_str yellow/clear, walk=1 for 8 cycles.
  - A second pulse during walk → another walk after the next round-robin turn.
- reset_n driven low mid-yellow, asynchronously between edges → outputs go 00/walk=0/active_phase=7 immediately.
  - After release with ew_left and ns_str requesting → ew_left granted first (pointer restarted at 0).
- Continuous assertion pass over a randomized 10k-cycle sensor run → one-hot non-red, no 11 encoding, yellow precedes every red after green.
